highscore_ctrl: RTL and testbench
=================================

# highscore_ctrl

Game-over high-score sequencer. It shares one external 7-segment digit comparator to decide whether the final score beats the stored high score, working one digit at a time from the most significant digit down. On a new record it re-encodes the score into the high-score display registers, which drive the HEX displays directly. It sits between the score counter and the high-score HEX outputs, and it is the only master of the shared comparator.

## Interface
- `NDIG`, default 3: number of decimal digits in both score and high score (1–6).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears the FSM and the high score.
- `start` in 1: one-cycle request to evaluate `score`; ignored while `busy`.
- `hi_clear` in 1: one-cycle request to reset the high score to zero; honoured only in IDLE.
- `score` in `4*NDIG`: BCD score, digit 0 in bits [3:0].
- `cmp_hex` out 7: 7-seg pattern presented to the shared comparator (active-low segments).
- `cmp_num` out 4: number presented to the comparator.
- `cmp_gt` in 1: comparator result, high when `cmp_num` is greater than the value of `cmp_hex`; combinational, same cycle.
- `hi_hex` out `7*NDIG`: high-score display patterns, digit 0 in bits [6:0].
- `busy` out 1: evaluation in progress.
- `done` out 1: one-cycle pulse at the end of every evaluation.
- `new_record` out 1: valid only with `done`; high when the high score was replaced.

## Operation
- States: IDLE, GT, GE, UPDATE, FINISH. The digit index `idx` is ceil(log2 NDIG) bits wide (min 1).
- **IDLE**
  - `start`: latch `score` into `s_lat`, saturating each digit above 9 to 9. Set `idx = NDIG-1` and go to GT.
  - `hi_clear` (without `start`): every `hi_hex` digit becomes 7'b1000000. Stay in IDLE.
  - `hi_clear` and `start` in the same cycle: `hi_clear` wins and `start` is dropped.
- **GT**
  - Drives `cmp_hex = hi_hex[idx]` and `cmp_num = s_lat[idx]`.
  - `cmp_gt=1`: go to UPDATE. Otherwise go to GE.
- **GE**
  - Drives `cmp_num = s_lat[idx]+1` (4-bit; 9+1=10, no overflow).
  - `cmp_gt=0`: the score digit is less, so go to FINISH with no record.
  - `cmp_gt=1`: the digits are equal. If `idx==0`, go to FINISH with no record (a tie is not a record). Otherwise decrement `idx` and go to GT.
- **UPDATE**: `hi_hex[i] = seg(s_lat[i])` for all i; set the record flag; go to FINISH.
- **FINISH**: `done=1`, `new_record` = record flag; clear the flag; go to IDLE.
- `seg()` encoding, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- The comparator maps any unrecognised pattern to 0. The controller relies on this only under the blanking option.
- `cmp_hex` and `cmp_num` are 0 in IDLE, UPDATE and FINISH.

## Timing
- Reset values: FSM in IDLE, `busy=0`, `done=0`, `new_record=0`, `cmp_hex=0`, `cmp_num=0`, every `hi_hex` digit 7'b1000000 (blanking variant: see Configuration).
- `busy` is high in GT, GE, UPDATE and FINISH, and low in the cycle after FINISH.
- Latency, counted from the `start` edge T (first GT cycle is T+1):
  - MSD greater: UPDATE at T+2, `done` at T+3.
  - MSD less: GE at T+2, `done` at T+3.
  - All digits equal: `done` at T+2·NDIG+1.
  - Record decided at digit k: `done` at T+2·(NDIG-1-k)+3.
- `cmp_gt` is sampled at the clock edge ending each GT/GE cycle. The comparator path must close in one cycle.
- `hi_hex` changes only at the UPDATE edge, on `hi_clear`, or on reset.
- `reset` mid-evaluation aborts immediately: no `done` pulse, high score zeroed.
- `start` or `hi_clear` while `busy` is dropped, not queued.

## Configuration
- `HISCORE_BLANK_EN` defined:
  - UPDATE and `hi_clear` write 7'b1111111 (blank) for leading-zero digits above digit 0. Digit 0 always shows a numeral.
  - Reset leaves digits NDIG-1..1 blank and digit 0 at 7'b1000000.
  - Compare results are unchanged, because the comparator treats blank as 0.
- Undefined: every digit always shows a numeral, leading zeros included.

## Test plan
- Reset, then `start` with score=042 (NDIG=3), high=000 → MSD tie then 4>0 at digit 1; `done` at T+5 with `new_record=1`; `hi_hex` = {1000000, 0011001, 0100100}.
- high=042, `start` with score=042 → six compare cycles; `done` at T+7 with `new_record=0`; `hi_hex` unchanged.
- high=042, `start` with score=100 → GT hits on the MSD; `done` at T+3 with `new_record=1`.
- high=100, `start` with score=099 → GE fails on the MSD; `done` at T+3 with `new_record=0`.
- `start` pulsed again mid-evaluation, then `reset` asserted at T+2 → second `start` ignored; no `done`; `busy=0`; `hi_hex` = all 1000000 (digits 2..1 = 1111111 with `HISCORE_BLANK_EN`).
- `start` and `hi_clear` in the same IDLE cycle with high=042 → high score cleared to 000; `busy` stays 0; no `done`.

Source files
------------

// File: rtl/highscore_ctrl.sv
`timescale 1ns/1ps
// highscore_ctrl
//
// Game-over high-score sequencer. When the game ends it decides whether the
// final score beats the stored high score. It does this one digit at a time,
// starting at the most significant digit, using a single external 7-segment
// digit comparator. If the score is a new record, the score is re-encoded into
// the high-score display registers, which drive the HEX displays directly.
//
// Optional feature macro: HISCORE_BLANK_EN
//   When this macro is defined, leading-zero digits above digit 0 are blanked.
//   When it is undefined, every digit shows a numeral.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high; clears the FSM and the high score
//   start       one-cycle request to evaluate score (ignored while busy)
//   hi_clear    one-cycle request to zero the high score (honoured in IDLE only)
//   score       BCD score, digit 0 in bits [3:0]
//   cmp_hex     7-seg pattern presented to the shared comparator
//   cmp_num     number presented to the shared comparator
//   cmp_gt      comparator result: cmp_num > value(cmp_hex), same cycle
//   hi_hex      high-score display patterns, digit 0 in bits [6:0]
//   busy        evaluation in progress
//   done        one-cycle pulse at the end of every evaluation
//   new_record  qualified by done; high when the high score was replaced
module highscore_ctrl #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hi_clear,
  input  logic [4*NDIG-1:0] score,
  output logic [6:0]        cmp_hex,
  output logic [3:0]        cmp_num,
  input  logic              cmp_gt,
  output logic [7*NDIG-1:0] hi_hex,
  output logic              busy,
  output logic              done,
  output logic              new_record
);

  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GT     = 3'd1;
  localparam logic [2:0] S_GE     = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      default: r = 7'b0010000;
    endcase
    return r;
  endfunction

  function automatic logic [7*NDIG-1:0] enc_digits(input logic [4*NDIG-1:0] bcd);
    logic [7*NDIG-1:0] r;
`ifdef HISCORE_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    r = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      r[7*i +: 7] = seg(bcd[4*i +: 4]);
`ifdef HISCORE_BLANK_EN
      // Walk down from the MSD; once a non-zero digit appears, the digits
      // below it are no longer leading zeros. Digit 0 is never blanked.
      if (bcd[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  function automatic logic [4*NDIG-1:0] sat_digits(input logic [4*NDIG-1:0] bcd);
    logic [4*NDIG-1:0] r;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = (bcd[4*i +: 4] > 4'd9) ? 4'd9 : bcd[4*i +: 4];
    end
    return r;
  endfunction

  // Display pattern for a high score of zero. This is also the reset value.
  localparam logic [7*NDIG-1:0] HI_ZERO = enc_digits({(4*NDIG){1'b0}});

  logic [2:0]        state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [4*NDIG-1:0] s_lat_q, s_lat_d;
  logic [7*NDIG-1:0] hi_hex_q, hi_hex_d;
  logic              rec_q, rec_d;

  logic [3:0]        cur_s;
  logic [6:0]        cur_h;

  always_comb begin
    cur_s = 4'd0;
    cur_h = 7'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IDXW'(i)) begin
        cur_s = s_lat_q[4*i +: 4];
        cur_h = hi_hex_q[7*i +: 7];
      end
    end
  end

  // Comparing digits from the MSD down: GT catches "score digit greater".
  // Otherwise GE asks whether (digit+1) > hi, which means the digits are equal.
  // If that is false too, the score digit is smaller and the evaluation ends.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    s_lat_d  = s_lat_q;
    hi_hex_d = hi_hex_q;
    rec_d    = rec_q;
    cmp_hex  = 7'd0;
    cmp_num  = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (hi_clear) begin
          hi_hex_d = HI_ZERO;
        end else if (start) begin
          s_lat_d = sat_digits(score);
          idx_d   = IDXW'(NDIG - 1);
          state_d = S_GT;
        end
      end
      S_GT: begin
        cmp_hex = cur_h;
        cmp_num = cur_s;
        state_d = cmp_gt ? S_UPDATE : S_GE;
      end
      S_GE: begin
        cmp_hex = cur_h;
        cmp_num = cur_s + 4'd1;
        if (!cmp_gt || (idx_q == '0)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q - IDXW'(1);
          state_d = S_GT;
        end
      end
      S_UPDATE: begin
        hi_hex_d = enc_digits(s_lat_q);
        rec_d    = 1'b1;
        state_d  = S_FINISH;
      end
      S_FINISH: begin
        rec_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      s_lat_q  <= '0;
      hi_hex_q <= HI_ZERO;
      rec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      s_lat_q  <= s_lat_d;
      hi_hex_q <= hi_hex_d;
      rec_q    <= rec_d;
    end
  end

  assign hi_hex     = hi_hex_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign new_record = (state_q == S_FINISH) && rec_q;

endmodule

// File: tb/tb_highscore_ctrl.sv
`timescale 1ns/1ps
module tb_highscore_ctrl;

  localparam int N = 3;

`ifdef HISCORE_BLANK_EN
  localparam logic [6:0] LEAD0 = 7'b1111111;
`else
  localparam logic [6:0] LEAD0 = 7'b1000000;
`endif
  localparam logic [7*N-1:0] HZ = {LEAD0, LEAD0, 7'b1000000};

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           hi_clear;
  logic [4*N-1:0] score;
  logic [6:0]     cmp_hex;
  logic [3:0]     cmp_num;
  logic           cmp_gt;
  logic [7*N-1:0] hi_hex;
  logic           busy;
  logic           done;
  logic           new_record;

  int checks   = 0;
  int failures = 0;

  highscore_ctrl #(.NDIG(N)) dut (
    .clk(clk), .reset(rst), .start(start), .hi_clear(hi_clear), .score(score),
    .cmp_hex(cmp_hex), .cmp_num(cmp_num), .cmp_gt(cmp_gt), .hi_hex(hi_hex),
    .busy(busy), .done(done), .new_record(new_record)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (seg_of(d) == p) return d;
    return 0;
  endfunction

  // External shared comparator model.
  always_comb cmp_gt = (int'(cmp_num) > dec(cmp_hex));

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic int digit(input int v, input int i);
    return (v / pow10(i)) % 10;
  endfunction

  // Display image of a decimal value.
  function automatic logic [7*N-1:0] enc_val(input int v);
    logic [7*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[7*i +: 7] = seg_of(digit(v, i));
`ifdef HISCORE_BLANK_EN
      if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
`endif
    end
    return r;
  endfunction

  function automatic int sat_val(input logic [4*N-1:0] bcd);
    int v = 0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(bcd[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'(digit(v, i));
    return r;
  endfunction

  // Cycles from the start edge to done: first differing digit k from the MSD
  // costs 2*(N-1-k)+3; a full tie costs 2N+1.
  function automatic int lat_of(input int s, input int h);
    for (int i = N - 1; i >= 0; i--)
      if (digit(s, i) != digit(h, i)) return 2 * (N - 1 - i) + 3;
    return 2 * N + 1;
  endfunction

  // Behavioural model
  int m_hi, m_s, m_lat, m_cnt;
  bit m_busy, m_rec;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_cnt = 0; m_hi = 0; m_rec = 0; m_lat = 0; m_s = 0;
    end else if (m_busy) begin
      if (m_cnt == m_lat) m_busy = 0;
      else begin
        m_cnt++;
        if (m_cnt == m_lat && m_rec) m_hi = m_s;
      end
    end else if (hi_clear) begin
      m_hi = 0;
    end else if (start) begin
      m_s    = sat_val(score);
      m_rec  = (m_s > m_hi);
      m_lat  = lat_of(m_s, m_hi);
      m_cnt  = 1;
      m_busy = 1;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      int e_hex, e_num, last, idx, d;
      bit e_done;
      e_done = m_busy && (m_cnt == m_lat);
      e_hex = 0; e_num = 0;
      if (m_busy) begin
        last = m_rec ? m_lat - 2 : m_lat - 1;
        if (m_cnt <= last) begin
          idx   = N - 1 - (m_cnt - 1) / 2;
          e_hex = int'(enc_val(m_hi) >> (7 * idx)) & 'h7f;
          d     = digit(m_s, idx);
          e_num = (m_cnt % 2 == 1) ? d : d + 1;
        end
      end
      chk("m_busy", int'(busy), int'(m_busy));
      chk("m_done", int'(done), int'(e_done));
      chk("m_new_record", int'(new_record), int'(e_done && m_rec));
      chk("m_hi_hex", int'(hi_hex), int'(enc_val(m_hi)));
      chk("m_cmp_hex", int'(cmp_hex), e_hex);
      chk("m_cmp_num", int'(cmp_num), e_num);
    end
  end

  task automatic run_eval(input logic [4*N-1:0] sc, input int exp_lat,
                          input logic exp_rec, input string nm);
    int n;
    @(negedge clk);
    score = sc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, exp_lat);
    chk({nm, "_new_record"}, int'(new_record), int'(exp_rec));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hi_clear = 1'b0; score = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_new_record", int'(new_record), 0);
    chk("rst_cmp_hex", int'(cmp_hex), 0);
    chk("rst_cmp_num", int'(cmp_num), 0);
    chk("rst_hi_hex", int'(hi_hex), int'(HZ));
    rst = 1'b0;

    run_eval(12'h042, 5, 1'b1, "s042_h000");
    chk("s042_hi_hex", int'(hi_hex), int'({LEAD0, 7'b0011001, 7'b0100100}));
    run_eval(12'h042, 7, 1'b0, "s042_h042");
    chk("tie_hi_hex", int'(hi_hex), int'({LEAD0, 7'b0011001, 7'b0100100}));
    run_eval(12'h100, 3, 1'b1, "s100_h042");
    chk("s100_hi_hex", int'(hi_hex), int'({7'b1111001, 7'b1000000, 7'b1000000}));
    run_eval(12'h099, 3, 1'b0, "s099_h100");
    run_eval(12'h0F9, 3, 1'b0, "sat_h100");

    // Second start mid-evaluation, then reset aborts.
    @(negedge clk);
    score = 12'h999; start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_hi_hex", int'(hi_hex), int'(HZ));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end

    run_eval(12'h042, 5, 1'b1, "s042_again");
    @(negedge clk);
    score = 12'h999; start = 1'b1; hi_clear = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_clear = 1'b0;
    chk("clr_hi_hex", int'(hi_hex), int'(HZ));
    for (int i = 0; i < 5; i++) begin
      chk("clr_busy", int'(busy), 0);
      chk("clr_done", int'(done), 0);
      @(negedge clk);
    end

    // Randomized phase, checked per cycle against the model
    for (int c = 0; c < 4000; c++) begin
      int mode, pos;
      logic [4*N-1:0] b;
      @(negedge clk);
      mode = $urandom_range(0, 2);
      if (mode == 0) b = to_bcd(m_hi);
      else if (mode == 1) b = 12'($urandom);
      else begin
        b = to_bcd(m_hi);
        pos = $urandom_range(0, N - 1);
        b[4*pos +: 4] = 4'($urandom_range(0, 9));
      end
      score    = b;
      start    = ($urandom_range(0, 3) == 0);
      hi_clear = ($urandom_range(0, 40) == 0);
      rst      = ($urandom_range(0, 150) == 0);
    end
    @(negedge clk);
    start = 1'b0; hi_clear = 1'b0; rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
